// File: rtl/ysyx_25060170_seq_ctrl.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction/data memory under a response timeout, and counts retired instructions and active cycles.
module ysyx_25060170_seq_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_ifu_req,
    input  logic             i_ifu_rvalid,
    output logic             o_inst_latch_en,
    input  logic             i_dec_is_load,
    input  logic             i_dec_is_store,
    input  logic             i_dec_regw,
    input  logic             i_dec_ebreak,
    input  logic             i_dec_illegal,
    output logic             o_exu_en,
    output logic             o_lsu_req,
    output logic             o_lsu_wen,
    input  logic             i_lsu_rvalid,
    output logic             o_rf_wen,
    output logic             o_pc_wen,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_err,
    output logic [CNT_W-1:0] o_instret,
    output logic [CNT_W-1:0] o_cycles
);

    // state  | meaning
    // IDLE   | one cycle after reset release
    // FETCH  | ifu_req held until ifu_rvalid
    // DECODE | capture decode flags, trap check
    // EXEC   | ALU / branch evaluation
    // MEM    | lsu_req held until lsu_rvalid
    // WB     | register/PC write, retire
    // HALT   | ebreak, sticky until reset
    // ERR    | illegal opcode or timeout, sticky
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ld;
    logic              r_st;
    logic              r_regw;
    logic [TO_W-1:0]   r_wait;
    logic [CNT_W-1:0]  r_instret;
    logic [CNT_W-1:0]  r_cycles;
    logic              w_timeout;
    logic              w_waiting;
    logic              w_active;

    // A response in the same cycle the limit is reached still wins: rvalid is checked first below.
    assign w_timeout = (TIMEOUT != 0) && (r_wait == TO_W'(TIMEOUT));
    assign w_active  = r_state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
    assign w_waiting = (w_next == r_state) && (r_state == S_FETCH || r_state == S_MEM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (i_ifu_rvalid)   w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DECODE: begin
                if (i_dec_illegal)     w_next = S_ERR;
                else if (i_dec_ebreak) w_next = S_HALT;
                else                   w_next = S_EXEC;
            end
            S_EXEC:   w_next = (r_ld || r_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (i_lsu_rvalid)   w_next = S_WB;
                else if (w_timeout) w_next = S_ERR;
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            S_ERR:    w_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld   <= 1'b0;
            r_st   <= 1'b0;
            r_regw <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_ld   <= i_dec_is_load;
            r_st   <= i_dec_is_store;
            r_regw <= i_dec_regw;
        end
    end

    // Any cycle that is not a continued wait clears the counter, so entry to FETCH/MEM starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_waiting) begin
            r_wait <= r_wait + TO_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
            r_cycles  <= '0;
        end else begin
            if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
            if (w_active)        r_cycles  <= r_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        o_ifu_req       = 1'b0;
        o_inst_latch_en = 1'b0;
        o_exu_en        = 1'b0;
        o_lsu_req       = 1'b0;
        o_lsu_wen       = 1'b0;
        o_rf_wen        = 1'b0;
        o_pc_wen        = 1'b0;
        o_halted        = 1'b0;
        o_err           = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_ifu_req       = 1'b1;
                o_inst_latch_en = i_ifu_rvalid;
            end
            S_EXEC:  o_exu_en = 1'b1;
            S_MEM: begin
                o_lsu_req = 1'b1;
                o_lsu_wen = r_st;
            end
            S_WB: begin
                o_rf_wen = r_regw;
                o_pc_wen = 1'b1;
            end
            S_HALT:  o_halted = 1'b1;
            S_ERR:   o_err    = 1'b1;
            default: ;
        endcase
    end

    assign o_state   = r_state;
    assign o_instret = r_instret;
    assign o_cycles  = r_cycles;

endmodule

// File: tb/tb_ysyx_25060170_seq_ctrl.sv
// Bench for the sequencer: table vectors, randomized instruction stream checked against a
// per-instruction latency model, plus directed timeout, trap, reset and counter-wrap sequences.
module tb_ysyx_25060170_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_w_n = 1'b0;
    logic        i_ifu_rvalid = 1'b0;
    logic        i_dec_is_load = 1'b0;
    logic        i_dec_is_store = 1'b0;
    logic        i_dec_regw = 1'b0;
    logic        i_dec_ebreak = 1'b0;
    logic        i_dec_illegal = 1'b0;
    logic        i_lsu_rvalid = 1'b0;

    logic        o_ifu_req, o_inst_latch_en, o_exu_en, o_lsu_req, o_lsu_wen;
    logic        o_rf_wen, o_pc_wen, o_halted, o_err;
    logic [2:0]  o_state;
    logic [31:0] o_instret, o_cycles;

    logic        w_ifu_req, w_inst_latch_en, w_exu_en, w_lsu_req, w_lsu_wen;
    logic        w_rf_wen, w_pc_wen, w_halted, w_err;
    logic [2:0]  w_state;
    logic [3:0]  w_instret, w_cycles;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_instret;
    logic [31:0] m_cycles;
    bit          wrap_en = 1'b0;

    always #5 clk = ~clk;

    ysyx_25060170_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .o_ifu_req(o_ifu_req), .i_ifu_rvalid(i_ifu_rvalid), .o_inst_latch_en(o_inst_latch_en),
        .i_dec_is_load(i_dec_is_load), .i_dec_is_store(i_dec_is_store), .i_dec_regw(i_dec_regw),
        .i_dec_ebreak(i_dec_ebreak), .i_dec_illegal(i_dec_illegal),
        .o_exu_en(o_exu_en), .o_lsu_req(o_lsu_req), .o_lsu_wen(o_lsu_wen), .i_lsu_rvalid(i_lsu_rvalid),
        .o_rf_wen(o_rf_wen), .o_pc_wen(o_pc_wen), .o_state(o_state), .o_halted(o_halted),
        .o_err(o_err), .o_instret(o_instret), .o_cycles(o_cycles)
    );

    // Narrow-counter, short-timeout instance sharing the same stimulus; used for wrap and timeout limits.
    ysyx_25060170_seq_ctrl #(.TIMEOUT(3), .TO_W(2), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_w_n),
        .o_ifu_req(w_ifu_req), .i_ifu_rvalid(i_ifu_rvalid), .o_inst_latch_en(w_inst_latch_en),
        .i_dec_is_load(i_dec_is_load), .i_dec_is_store(i_dec_is_store), .i_dec_regw(i_dec_regw),
        .i_dec_ebreak(i_dec_ebreak), .i_dec_illegal(i_dec_illegal),
        .o_exu_en(w_exu_en), .o_lsu_req(w_lsu_req), .o_lsu_wen(w_lsu_wen), .i_lsu_rvalid(i_lsu_rvalid),
        .o_rf_wen(w_rf_wen), .o_pc_wen(w_pc_wen), .o_state(w_state), .o_halted(w_halted),
        .o_err(w_err), .o_instret(w_instret), .o_cycles(w_cycles)
    );

    typedef struct {
        bit ld;
        bit st;
        bit regw;
        int fw;
        int mw;
        int e_len;
        int e_lsu;
        bit e_wen;
        bit e_rfw;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction length from the stage rules: FETCH waits + 1, DECODE, EXEC, optional MEM waits + 1, WB.
    function automatic int model_len(input bit ld, input bit st, input int fw, input int mw);
        return (fw + 1) + 1 + 1 + ((ld || st) ? (mw + 1) : 0) + 1;
    endfunction

    task automatic clear_inputs();
        i_ifu_rvalid   = 1'b0;
        i_lsu_rvalid   = 1'b0;
        i_dec_is_load  = 1'b0;
        i_dec_is_store = 1'b0;
        i_dec_regw     = 1'b0;
        i_dec_ebreak   = 1'b0;
        i_dec_illegal  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        rst_w_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        if (wrap_en) rst_w_n = 1'b1;
        m_instret = '0;
        m_cycles  = '0;
    endtask

    // Drives one instruction starting in FETCH; rvalid timing comes from fw/mw, not from DUT state.
    task automatic run_instr(input bit ld, input bit st, input bit regw, input bit eb, input bit il,
                             input int fw, input int mw, input bit noise,
                             output int len, output int n_ifu, output int n_lsu, output int n_latch,
                             output bit saw_wen, output bit saw_rfw, output logic [2:0] fin,
                             output logic [31:0] ir, output logic [31:0] cy);
        bit done;
        bit ldst;
        done = 1'b0; len = 0; n_ifu = 0; n_lsu = 0; n_latch = 0;
        saw_wen = 1'b0; saw_rfw = 1'b0; fin = 3'd0;
        ldst = ld || st;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            i_dec_is_load  = ld;
            i_dec_is_store = st;
            i_dec_regw     = regw;
            i_dec_ebreak   = eb;
            i_dec_illegal  = il;
            if (noise && c != fw + 1) begin
                i_dec_is_load  = rbit();
                i_dec_is_store = rbit();
                i_dec_regw     = rbit();
                i_dec_ebreak   = rbit();
                i_dec_illegal  = rbit();
            end
            i_ifu_rvalid = (c == fw);
            if (noise && c > fw) i_ifu_rvalid = rbit();
            i_lsu_rvalid = ldst && (c == fw + 3 + mw);
            if (noise && (!ldst || c < fw + 3)) i_lsu_rvalid = rbit();
            #1;
            if (o_ifu_req) n_ifu++;
            if (o_lsu_req) n_lsu++;
            if (o_inst_latch_en) n_latch++;
            if (o_lsu_wen) saw_wen = 1'b1;
            if (o_rf_wen) saw_rfw = 1'b1;
            if (o_pc_wen || o_halted || o_err) begin
                len  = c + 1;
                fin  = o_state;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("instr_budget", 64'(done), 64'd1);
            fin = o_state;
        end
        @(posedge clk);
        #1;
        ir = o_instret;
        cy = o_cycles;
        clear_inputs();
    endtask

    initial begin
        vec_t        tbl [6];
        int          len, n_ifu, n_lsu, n_latch, n;
        bit          saw_wen, saw_rfw, got;
        logic [2:0]  fin;
        logic [31:0] ir, cy;
        bit          ld, st, regw;
        int          fw, mw;

        //           ld    st    regw  fw mw len lsu wen   rfw
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1, 0, 5,  0,  1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1, 1, 7,  2,  1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1, 1, 7,  2,  1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 4,  0,  1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2, 0, 7,  1,  1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 0, 3, 8,  4,  1'b0, 1'b1};

        clear_inputs();
        #2;
        chk("reset_state", 64'(o_state), 64'd0);
        chk("reset_strobes", 64'({o_ifu_req, o_inst_latch_en, o_exu_en, o_lsu_req, o_lsu_wen,
                                  o_rf_wen, o_pc_wen, o_halted, o_err}), 64'd0);
        chk("reset_counters", 64'({o_instret, o_cycles}), 64'd0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_instr(tbl[i].ld, tbl[i].st, tbl[i].regw, 1'b0, 1'b0, tbl[i].fw, tbl[i].mw, 1'b0,
                      len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
            m_instret = m_instret + 1;
            m_cycles  = m_cycles + 32'(model_len(tbl[i].ld, tbl[i].st, tbl[i].fw, tbl[i].mw));
            chk($sformatf("tbl%0d_len", i), 64'(len), 64'(tbl[i].e_len));
            chk($sformatf("tbl%0d_ifu_cycles", i), 64'(n_ifu), 64'(tbl[i].fw + 1));
            chk($sformatf("tbl%0d_lsu_cycles", i), 64'(n_lsu), 64'(tbl[i].e_lsu));
            chk($sformatf("tbl%0d_latch", i), 64'(n_latch), 64'd1);
            chk($sformatf("tbl%0d_lsu_wen", i), 64'(saw_wen), 64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_rf_wen", i), 64'(saw_rfw), 64'(tbl[i].e_rfw));
            chk($sformatf("tbl%0d_wb_state", i), 64'(fin), 64'd5);
            chk($sformatf("tbl%0d_instret", i), 64'(ir), 64'(m_instret));
            chk($sformatf("tbl%0d_cycles", i), 64'(cy), 64'(m_cycles));
        end

        for (int i = 0; i < 30; i++) begin
            ld   = ($urandom_range(0, 2) == 0);
            st   = ($urandom_range(0, 2) == 0);
            regw = rbit();
            fw   = int'($urandom_range(0, 6));
            mw   = int'($urandom_range(0, 5));
            run_instr(ld, st, regw, 1'b0, 1'b0, fw, mw, 1'b1,
                      len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
            m_instret = m_instret + 1;
            m_cycles  = m_cycles + 32'(model_len(ld, st, fw, mw));
            chk($sformatf("rnd%0d_len", i), 64'(len), 64'(model_len(ld, st, fw, mw)));
            chk($sformatf("rnd%0d_lsu_cycles", i), 64'(n_lsu), 64'((ld || st) ? mw + 1 : 0));
            chk($sformatf("rnd%0d_strobes", i), 64'({n_latch[3:0], saw_wen, saw_rfw}),
                64'({4'd1, st, regw}));
            chk($sformatf("rnd%0d_counters", i), 64'({ir, cy}), 64'({m_instret, m_cycles}));
        end

        n = 0;
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            i_ifu_rvalid = 1'b0;
            i_lsu_rvalid = rbit();
            #1;
            if (o_ifu_req) n++;
            if (o_err) begin
                got = 1'b1;
                break;
            end
        end
        i_lsu_rvalid = 1'b0;
        m_cycles = m_cycles + 32'd201;
        chk("timeout_err_seen", 64'(got), 64'd1);
        chk("timeout_fetch_cycles", 64'(n), 64'd201);
        repeat (3) @(negedge clk);
        #1;
        chk("timeout_sticky_state", 64'(o_state), 64'd7);
        chk("timeout_no_req", 64'({o_ifu_req, o_err}), 64'b01);
        chk("timeout_counters_frozen", 64'({o_instret, o_cycles}), 64'({m_instret, m_cycles}));

        do_reset();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 200, 0, 1'b0,
                  len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
        chk("rvalid_at_limit_state", 64'(fin), 64'd5);
        chk("rvalid_at_limit_len", 64'(len), 64'd204);
        chk("rvalid_at_limit_counters", 64'({ir, cy}), 64'({32'd1, 32'd204}));

        do_reset();
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0,
                  len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
        chk("ebreak_state", 64'(fin), 64'd6);
        chk("ebreak_len", 64'(len), 64'd4);
        chk("ebreak_counters", 64'({ir, cy}), 64'({32'd0, 32'd3}));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_ifu_rvalid = 1'b1;
            #1;
            chk($sformatf("halt_hold%0d", k), 64'({o_halted, o_ifu_req, o_inst_latch_en, o_pc_wen}),
                64'b1000);
        end
        clear_inputs();

        do_reset();
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0,
                  len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
        chk("illegal_over_ebreak_state", 64'(fin), 64'd7);
        chk("illegal_over_ebreak_flags", 64'({o_err, o_halted}), 64'b10);

        do_reset();
        @(negedge clk);
        i_ifu_rvalid  = 1'b1;
        i_dec_is_load = 1'b1;
        i_dec_regw    = 1'b1;
        @(negedge clk);
        i_ifu_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_mem_req", 64'({o_state, o_lsu_req}), 64'({3'd4, 1'b1}));
        chk("mid_mem_cycles", 64'(o_cycles), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_strobes", 64'({o_ifu_req, o_inst_latch_en, o_exu_en, o_lsu_req, o_lsu_wen,
                                        o_rf_wen, o_pc_wen, o_halted, o_err}), 64'd0);
        chk("async_reset_state_counters", 64'({o_state, o_instret, o_cycles}), 64'd0);
        clear_inputs();
        i_lsu_rvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("stale_lsu_rvalid_fetch0", 64'({o_state, o_lsu_req}), 64'({3'd1, 1'b0}));
        @(negedge clk);
        #1;
        chk("stale_lsu_rvalid_fetch1", 64'(o_state), 64'd1);
        m_instret = '0;
        m_cycles  = 32'd2;
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0,
                  len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
        m_instret = m_instret + 1;
        m_cycles  = m_cycles + 32'(model_len(1'b1, 1'b0, 0, 2));
        chk("after_reset_load_lsu", 64'(n_lsu), 64'd3);
        chk("after_reset_counters", 64'({ir, cy}), 64'({m_instret, m_cycles}));

        wrap_en = 1'b1;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0,
                      len, n_ifu, n_lsu, n_latch, saw_wen, saw_rfw, fin, ir, cy);
            if (k == 14) chk("wrap_instret_max", 64'(w_instret), 64'hF);
        end
        chk("wrap_instret_zero", 64'(w_instret), 64'd0);
        chk("wrap_cycles_zero", 64'(w_cycles), 64'd0);
        chk("wide_instret_16", 64'(o_instret), 64'd16);
        repeat (5) begin
            @(negedge clk);
            i_ifu_rvalid = 1'b0;
        end
        #1;
        chk("short_timeout_err", 64'({w_err, w_state, w_cycles}), 64'({1'b1, 3'd7, 4'd4}));
        chk("long_timeout_still_fetch", 64'({o_err, o_state}), 64'({1'b0, 3'd1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global time limit");
    end

endmodule
